// File: rtl/fft_bf_sequencer_if.sv
// Handshake bundle between the FFT butterfly sequencer and the register-file/datapath side.
// The sequencer takes the master modport. The datapath or the bench takes the slave modport.
interface fft_bf_sequencer_if #(
  parameter int LOG2N = 10
);
  logic             start;
  logic             stall;
  logic [LOG2N-1:0] i_top;
  logic [LOG2N-1:0] i_bot;
  logic [LOG2N-2:0] tw_idx;
  logic             write_en;
  logic [3:0]       stage;
  logic             busy;
  logic             done;

  modport master (
    input  start, stall,
    output i_top, i_bot, tw_idx, write_en, stage, busy, done
  );

  modport slave (
    output start, stall,
    input  i_top, i_bot, tw_idx, write_en, stage, busy, done
  );
endinterface

// File: rtl/fft_bf_sequencer.sv
// Radix-2 DIT in-place FFT control: walks stages and butterflies and drives the index pair,
// the twiddle index and the write strobe for a shared complex register file.
module fft_bf_sequencer #(
  parameter int LOG2N  = 10,
  parameter int BF_LAT = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  fft_bf_sequencer_if.master   bus
);
  localparam int BW = LOG2N - 1;
  localparam int PW = (BF_LAT > 0) ? $clog2(BF_LAT + 1) : 1;
  localparam logic [3:0]    S_MAX  = 4'(LOG2N - 1);
  localparam logic [BW-1:0] B_LAST = '1;
  localparam logic [PW-1:0] P_LAST = PW'(BF_LAT);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    s, s_nxt;
  logic [BW-1:0] b, b_nxt;
  logic [PW-1:0] p, p_nxt;
  logic          we;

  logic [LOG2N-1:0] b_ext, half, pos, top_nxt, bot_nxt;
  logic [BW-1:0]    tw_nxt;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    b_nxt     = b;
    p_nxt     = p;
    we        = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          s_nxt     = '0;
          b_nxt     = '0;
          p_nxt     = '0;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          if (p == P_LAST) begin
            we    = 1'b1;
            p_nxt = '0;
            if (b == B_LAST) begin
              b_nxt = '0;
              if (s == S_MAX) begin
                state_nxt = DONE;
                s_nxt     = '0;
              end else begin
                s_nxt = s + 4'd1;
              end
            end else begin
              b_nxt = b + BW'(1);
            end
          end else begin
            p_nxt = p + PW'(1);
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Indices for the next cycle's butterfly. Operand i_top always has bit s clear, so i_bot cannot wrap.
  always_comb begin
    b_ext   = {1'b0, b_nxt};
    half    = LOG2N'(1) << s_nxt;
    pos     = b_ext & (half - LOG2N'(1));
    top_nxt = ((b_ext >> s_nxt) << ({1'b0, s_nxt} + 5'd1)) | pos;
    bot_nxt = top_nxt + half;
    tw_nxt  = BW'(pos << (S_MAX - s_nxt));
  end

  // NOTE: write_en is combinational in stall so a stalled write phase never strobes the file.
  assign bus.write_en = we;

  // NOTE: sequential state uses non-blocking assignments only. Reset is asynchronous, so the
  // outputs drop to zero the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      s          <= '0;
      b          <= '0;
      p          <= '0;
      bus.i_top  <= '0;
      bus.i_bot  <= '0;
      bus.tw_idx <= '0;
      bus.stage  <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      state      <= state_nxt;
      s          <= s_nxt;
      b          <= b_nxt;
      p          <= p_nxt;
      bus.i_top  <= (state_nxt == RUN) ? top_nxt : '0;
      bus.i_bot  <= (state_nxt == RUN) ? bot_nxt : '0;
      bus.tw_idx <= (state_nxt == RUN) ? tw_nxt  : '0;
      bus.stage  <= (state_nxt == RUN) ? s_nxt   : '0;
      bus.busy   <= (state_nxt == RUN);
      bus.done   <= (state_nxt == DONE);
    end
  end
endmodule

// File: tb/tb_fft_bf_sequencer.sv
// Bench for three sequencer configurations: 8-point with BF_LAT 1 and 0, and 1024-point with a real-valued FFT model.
// A scoreboard queue holds the butterflies each transform must write, in order.
module tb_fft_bf_sequencer;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_bf_sequencer_if #(.LOG2N(3))  bus3 ();
  fft_bf_sequencer_if #(.LOG2N(3))  bus0 ();
  fft_bf_sequencer_if #(.LOG2N(10)) bus10 ();

  fft_bf_sequencer #(.LOG2N(3),  .BF_LAT(1)) u_d3  (.clk(clk), .rst_n(rst_n), .bus(bus3));
  fft_bf_sequencer #(.LOG2N(3),  .BF_LAT(0)) u_d0  (.clk(clk), .rst_n(rst_n), .bus(bus0));
  fft_bf_sequencer #(.LOG2N(10), .BF_LAT(2)) u_d10 (.clk(clk), .rst_n(rst_n), .bus(bus10));

  typedef struct packed {
    logic [9:0] top;
    logic [9:0] bot;
    logic [8:0] tw;
    logic [3:0] stage;
    logic       we;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct packed {
    logic [3:0] stage;
    logic [9:0] top;
    logic [9:0] bot;
    logic [8:0] tw;
  } bf_t;

  typedef struct {
    int dut;        // 0: 8-pt BF_LAT=1, 1: 8-pt BF_LAT=0, 2: 1024-pt BF_LAT=2
    int stall_bf;
    int stall_len;
    int poke;
    int hold;
    int exp_busy;
    int exp_writes;
    int exp_done;
  } vec_t;

  obs_t obs0, obs1, obs2;
  bf_t  sb[$];
  bf_t  tbl[12];
  vec_t vecs[6];
  real  re_m[1024];
  real  im_m[1024];
  int   vec_cnt = 0;
  int   miscompares = 0;

  always_comb begin
    obs0 = '{top: 10'(bus3.i_top), bot: 10'(bus3.i_bot), tw: 9'(bus3.tw_idx), stage: bus3.stage,
             we: bus3.write_en, busy: bus3.busy, done: bus3.done};
    obs1 = '{top: 10'(bus0.i_top), bot: 10'(bus0.i_bot), tw: 9'(bus0.tw_idx), stage: bus0.stage,
             we: bus0.write_en, busy: bus0.busy, done: bus0.done};
    obs2 = '{top: bus10.i_top, bot: bus10.i_bot, tw: bus10.tw_idx, stage: bus10.stage,
             we: bus10.write_en, busy: bus10.busy, done: bus10.done};
  end

  function automatic obs_t pick(input int k);
    case (k)
      0:       return obs0;
      1:       return obs1;
      default: return obs2;
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    vec_cnt++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_start(input int k, input logic v);
    case (k)
      0:       bus3.start = v;
      1:       bus0.start = v;
      default: bus10.start = v;
    endcase
  endtask

  task automatic set_stall(input int k, input logic v);
    case (k)
      0:       bus3.stall = v;
      1:       bus0.stall = v;
      default: bus10.stall = v;
    endcase
  endtask

  // Golden butterfly on the register-file model: x[t] += W*x[b], x[b] = old x[t] - W*x[b].
  task automatic butterfly(input int t, input int b, input int tw);
    real wr, wi, tr, ti, ar, ai;
    wr = $cos(2.0 * PI * tw / 1024.0);
    wi = -$sin(2.0 * PI * tw / 1024.0);
    tr = re_m[b] * wr - im_m[b] * wi;
    ti = re_m[b] * wi + im_m[b] * wr;
    ar = re_m[t];
    ai = im_m[t];
    re_m[t] = ar + tr;
    im_m[t] = ai + ti;
    re_m[b] = ar - tr;
    im_m[b] = ai - ti;
  endtask

  task automatic run(input vec_t v);
    int   k, busy_n, wr_n, done_n, run_cur, run_max, starts, done_cyc, stall_left, post, bad;
    bit   stall_used, finished;
    obs_t o, prev;
    bf_t  e, last;
    k = v.dut;
    sb.delete();
    if (k == 2) begin
      for (int s = 0; s < 10; s++)
        for (int g = 0; g < 1024; g += 2 << s)
          for (int j = 0; j < (1 << s); j++)
            sb.push_back('{stage: 4'(s), top: 10'(g + j), bot: 10'(g + j + (1 << s)),
                           tw: 9'(j * (512 >> s))});
      for (int i = 0; i < 1024; i++) begin
        re_m[i] = (i == 0) ? 1.0 : 0.0;
        im_m[i] = 0.0;
      end
    end else begin
      for (int r = 0; r < (v.hold != 0 ? 2 : 1); r++)
        for (int i = 0; i < 12; i++) sb.push_back(tbl[i]);
    end
    {busy_n, wr_n, done_n, run_cur, run_max, starts, stall_left, post} = '0;
    done_cyc = -1;
    stall_used = 1'b0;
    finished = 1'b0;
    prev = '0;
    last = '0;
    @(posedge clk); #1 set_start(k, 1'b1);
    @(posedge clk); #1 if (v.hold == 0) set_start(k, 1'b0);
    for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
      @(negedge clk);
      o = pick(k);
      if (o.busy && !prev.busy) begin
        starts++;
        if (done_cyc >= 0) check("restart_gap_after_done", cyc - done_cyc, 2);
      end
      if (o.busy) busy_n++;
      if (o.we) begin
        wr_n++;
        if (sb.size() == 0) check("unexpected_write", 1, 0);
        else begin
          e = sb.pop_front();
          check("wr_top", o.top, e.top);
          check("wr_bot", o.bot, e.bot);
          check("wr_tw", o.tw, e.tw);
          check("wr_stage", o.stage, e.stage);
          if (k == 0) begin
            check("held_idx_before_write", {prev.top, prev.bot}, {o.top, o.bot});
            check("no_write_first_phase", prev.we, 0);
          end
          if (k == 2) butterfly(int'(o.top), int'(o.bot), int'(o.tw));
          last = '{stage: o.stage, top: o.top, bot: o.bot, tw: o.tw};
        end
      end
      run_cur = o.we ? run_cur + 1 : 0;
      if (run_cur > run_max) run_max = run_cur;
      if (o.done) begin
        done_n++;
        check("done_after_last_write", prev.we, 1);
        check("done_busy_low", o.busy, 0);
        done_cyc = cyc;
      end
      if (v.hold != 0) set_start(k, starts < 2);
      else if (v.poke != 0) set_start(k, (o.busy && busy_n == 5) || o.done);
      if (stall_left > 0) begin
        if (sb.size() > 0) check("stall_frozen_idx", {o.top, o.bot, o.tw}, {sb[0].top, sb[0].bot, sb[0].tw});
        check("stall_write_en", o.we, 0);
        stall_left--;
        if (stall_left == 0) begin
          @(posedge clk); #1 set_stall(k, 1'b0);
        end
      end else if (v.stall_len > 0 && !stall_used && o.busy && !o.we && wr_n == v.stall_bf) begin
        @(posedge clk); #1 set_stall(k, 1'b1);
        stall_left = v.stall_len;
        stall_used = 1'b1;
      end
      prev = o;
      if (done_n >= v.exp_done) post++;
      if (post > 3) finished = 1'b1;
    end
    set_start(k, 1'b0);
    set_stall(k, 1'b0);
    check("run_completed_in_budget", finished, 1);
    check("busy_cycles", busy_n, v.exp_busy);
    check("writes", wr_n, v.exp_writes);
    check("done_pulses", done_n, v.exp_done);
    check("scoreboard_drained", sb.size(), 0);
    if (k == 1) check("consecutive_writes", run_max, 12);
    if (k == 2) begin
      check("final_pair", {last.top, last.bot, last.tw}, {10'd511, 10'd1023, 9'd511});
      bad = 0;
      for (int i = 0; i < 1024; i++)
        if ((re_m[i] - 1.0 > 1e-6) || (1.0 - re_m[i] > 1e-6) || (im_m[i] > 1e-6) || (im_m[i] < -1e-6))
          bad++;
      check("impulse_fft_bad_bins", bad, 0);
    end
  endtask

  initial begin
    int   t_top[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int   t_bot[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int   t_tw[12]  = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    obs_t o;
    bit   found;
    for (int i = 0; i < 12; i++)
      tbl[i] = '{stage: 4'(i / 4), top: 10'(t_top[i]), bot: 10'(t_bot[i]), tw: 9'(t_tw[i])};
    //           dut stall_bf len poke hold busy  writes done
    vecs[0] = '{0,   0,       0,  0,   0,   24,    12,    1};
    vecs[1] = '{1,   0,       0,  0,   0,   12,    12,    1};
    vecs[2] = '{0,   6,       5,  0,   0,   29,    12,    1};
    vecs[3] = '{0,   0,       0,  1,   0,   24,    12,    1};
    vecs[4] = '{0,   0,       0,  0,   1,   48,    24,    2};
    vecs[5] = '{2,   0,       0,  0,   0,   15360, 5120,  1};

    {bus3.start, bus3.stall, bus0.start, bus0.stall, bus10.start, bus10.stall} = '0;
    #12;
    for (int k = 0; k < 3; k++) check($sformatf("reset_outputs_dut%0d", k), pick(k), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_without_start", {obs0.busy, obs1.busy, obs2.busy}, 0);

    for (int i = 0; i < 6; i++) run(vecs[i]);

    // Abandon a transform mid-stage 1 with an off-edge reset, then restart from scratch.
    @(posedge clk); #1 set_start(0, 1'b1);
    @(posedge clk); #1 set_start(0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (obs0.stage == 4'd1) found = 1'b1;
    end
    check("reached_stage1", found, 1);
    #3 rst_n = 1'b0;
    #1 o = obs0;
    check("async_reset_idx", {o.top, o.bot, o.tw}, 0);
    check("async_reset_ctrl", {o.we, o.busy, o.done, o.stage}, 0);
    #3 check("reset_held_through_edge", obs0, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset_release", {obs0.busy, obs0.done, obs0.we}, 0);
    run(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end
endmodule
